// File: rtl/axi_r_return_router.sv
// rtl/axi_r_return_router.sv - routes slave R beats back to the master that issued each AR
//
// Records the issuing master of every AR in an in-order FIFO and steers the
// slave R channel to the master at the FIFO head until the beat with rlast.
// Optional feature macro: R_ROUTER_BEAT_COUNT_EN (enables the routed-beat counter).
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   ar_push, ar_master  record master index of an AR accepted by the slave
//   ar_full             ordering FIFO full; upstream must not push
//   s_r*                slave R channel (valid/ready/data/resp/last)
//   m_rvalid, m_rready  per-master R handshake (valid is one-hot)
//   m_rdata/rresp/rlast R payload broadcast to all masters
//   busy                mid-burst (FSM in BURST)
//   err_unexpected      sticky: beat arrived with no outstanding burst
//   beat_count          routed-beat counter (0 when the feature is disabled)
module axi_r_return_router #(
  parameter int NUM_MASTERS = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 3,
  localparam int MIDX_W     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ar_push,
  input  logic [MIDX_W-1:0]      ar_master,
  output logic                   ar_full,
  input  logic                   s_rvalid,
  input  logic [DATA_WIDTH-1:0]  s_rdata,
  input  logic [1:0]             s_rresp,
  input  logic                   s_rlast,
  output logic                   s_rready,
  output logic [NUM_MASTERS-1:0] m_rvalid,
  input  logic [NUM_MASTERS-1:0] m_rready,
  output logic [DATA_WIDTH-1:0]  m_rdata,
  output logic [1:0]             m_rresp,
  output logic                   m_rlast,
  output logic                   busy,
  output logic                   err_unexpected,
  output logic [15:0]            beat_count
);

  localparam int ENTRIES = 1 << DEPTH;
  localparam logic [DEPTH:0] FULL_CNT = (DEPTH+1)'(ENTRIES);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;

  logic [MIDX_W-1:0] mem_q [ENTRIES];
  logic [MIDX_W-1:0] mem_d [ENTRIES];
  logic [DEPTH-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH:0]    count_q, count_d;
  state_e            state_q, state_d;
  logic              err_q, err_d;

  logic              empty, full, ready_int, routed, pop, push_ok;
  logic [MIDX_W-1:0] head;
  logic [NUM_MASTERS-1:0] rvalid_int;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign head  = mem_q[rd_ptr_q];

  // With nothing outstanding the slave is always accepted so stray beats drain.
  assign ready_int = empty ? 1'b1 : m_rready[head];
  assign routed    = s_rvalid && ready_int && !empty;
  assign pop       = routed && s_rlast;
  // A push while full is only safe when the head entry retires this cycle.
  assign push_ok   = ar_push && (!full || pop);

  always_comb begin
    rvalid_int = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      rvalid_int[i] = !empty && s_rvalid && (head == MIDX_W'(i));
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    err_d    = err_q | (empty && s_rvalid);

    if (push_ok) begin
      mem_d[wr_ptr_q] = ar_master;
      wr_ptr_d        = wr_ptr_q + DEPTH'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + DEPTH'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (DEPTH+1)'(1);
      2'b01:   count_d = count_q - (DEPTH+1)'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE:    if (routed && !s_rlast) state_d = BURST;
      BURST:   if (routed && s_rlast)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      err_q    <= err_d;
    end
  end

  // Entry contents need no reset: they are only read while count is non-zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Handshake outputs are forced to their idle values while reset is asserted,
  // before the state registers have been cleared.
  assign ar_full        = full && !rst;
  assign s_rready       = rst ? 1'b1 : ready_int;
  assign m_rvalid       = rst ? '0 : rvalid_int;
  assign busy           = (state_q == BURST) && !rst;
  assign err_unexpected = err_q;

  assign m_rdata = s_rdata;
  assign m_rresp = s_rresp;
  assign m_rlast = s_rlast;

`ifdef R_ROUTER_BEAT_COUNT_EN
  logic [15:0] beat_cnt_q, beat_cnt_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (routed && (beat_cnt_q != 16'hFFFF)) beat_cnt_d = beat_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) beat_cnt_q <= '0;
    else     beat_cnt_q <= beat_cnt_d;
  end

  assign beat_count = beat_cnt_q;
`else
  assign beat_count = 16'd0;
`endif

endmodule
